fifo_wptr_full: RTL

//  Write-side pointer and status generator for the async FIFO. Owns the binary

---
 rtl/fifo_wptr_full_pkg.sv | 19 +
 rtl/fifo_wptr_full_if.sv | 26 ++
 rtl/fifo_wptr_full_gray_to_bin.sv | 11 +
 rtl/fifo_wptr_full.sv | 60 ++++++
 4 files changed

// File: rtl/fifo_wptr_full_pkg.sv
// Shared definitions for the async FIFO write-side pointer logic.
package fifo_wptr_full_pkg;

  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_AF_MARGIN = 2;

  // Registered write-side status flags
  typedef struct packed {
    logic full;
    logic almost_full;
    logic overflow;
  } wstat_t;

  // Fill level at which almost-full trips
  function automatic int af_level(input int addr_w, input int margin);
    return (1 << addr_w) - margin;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side bundle: producer handshake, synced read pointer, RAM port and status.
interface fifo_wptr_full_if
  import fifo_wptr_full_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              winc;
  logic [ADDR_W:0]   rptr_sync;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wptr_gray;
  logic              wfull;
  logic              walmost_full;
  logic [ADDR_W:0]   wcount;
  logic              woverflow;

  modport master (
    output winc, rptr_sync,
    input  wen, waddr, wptr_gray, wfull, walmost_full, wcount, woverflow
  );

  modport slave (
    input  winc, rptr_sync,
    output wen, waddr, wptr_gray, wfull, walmost_full, wcount, woverflow
  );
endinterface

// File: rtl/fifo_wptr_full_gray_to_bin.sv
// Combinational Gray-to-binary converter; each bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end
endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, RAM address and full/almost-full/count/overflow generator.
module fifo_wptr_full
  import fifo_wptr_full_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AF_MARGIN = DEF_AF_MARGIN
) (
  input  logic              gen_clk,
  input  logic              reset,
  fifo_wptr_full_if.slave   wif
);
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] AF_LVL = PTR_W'(af_level(ADDR_W, AF_MARGIN));

  logic [ADDR_W:0] wbin, wgray, wcnt;
  logic [ADDR_W:0] wbin_next, wgray_next, fill_next;
  logic [ADDR_W:0] rbin, rfull_gray;
  wstat_t          stat;

  gray_to_bin #(.W(PTR_W)) u_rg2b (
    .gray (wif.rptr_sync),
    .bin  (rbin)
  );

  // A write is accepted only while not full; the write pointer and RAM
  // enable both key off the same registered full flag.
  assign wif.wen    = wif.winc & ~stat.full;
  assign wbin_next  = wbin + PTR_W'(wif.wen);
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign fill_next  = wbin_next - rbin;
  // Write pointer equals read pointer with the top two Gray bits inverted
  // exactly when the write side is one full lap ahead.
  assign rfull_gray = {~wif.rptr_sync[ADDR_W:ADDR_W-1], wif.rptr_sync[ADDR_W-2:0]};

  // Pointer and status registers; flags use next-state values so full
  // lands on the same edge as the filling write.
  always_ff @(posedge gen_clk) begin
    if (!reset) begin
      wbin  <= '0;
      wgray <= '0;
      wcnt  <= '0;
      stat  <= '0;
    end else begin
      wbin             <= wbin_next;
      wgray            <= wgray_next;
      wcnt             <= fill_next;
      stat.full        <= (wgray_next == rfull_gray);
      stat.almost_full <= (fill_next >= AF_LVL);
      stat.overflow    <= stat.overflow | (wif.winc & stat.full);
    end
  end

  // Gray pointer leaves straight from its flop for the cross-domain sampler.
  assign wif.waddr        = wbin[ADDR_W-1:0];
  assign wif.wptr_gray    = wgray;
  assign wif.wcount       = wcnt;
  assign wif.wfull        = stat.full;
  assign wif.walmost_full = stat.almost_full;
  assign wif.woverflow    = stat.overflow;
endmodule
